micro_sequencer: RTL and testbench



---
 rtl/micro_sequencer_pkg.sv | 49 ++++
 rtl/micro_sequencer_udecode_fields.sv | 37 +++
 rtl/micro_sequencer.sv | 104 ++++++++++
 tb/tb_micro_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared state encodings, instruction-register layout and sizing constants
// used by the micro-sequencer and the register file.
package micro_sequencer_pkg;

    localparam int unsigned CPU_STATES = 5;
    localparam int unsigned STATE_W    = $clog2(CPU_STATES);
    localparam int unsigned ALU_OPS    = 8;
    localparam int unsigned ALU_OP_W   = $clog2(ALU_OPS);

    localparam int unsigned IR_W     = 44;
    localparam int unsigned BT_W     = 10;
    localparam int unsigned IMM_W    = 11;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned CLASS_W  = 3;

    localparam int unsigned UOP_CLASS_HI = 43;
    localparam int unsigned UOP_CLASS_LO = 41;
    localparam int unsigned REG_DST_HI   = 39;
    localparam int unsigned REG_DST_LO   = 36;
    localparam int unsigned REG_SRC_HI   = 34;
    localparam int unsigned REG_SRC_LO   = 31;
    localparam int unsigned IMM_HI       = 30;
    localparam int unsigned IMM_LO       = 20;
    localparam int unsigned BT_HI        = 19;
    localparam int unsigned BT_LO        = 10;

    localparam int unsigned FLAG_IS_IMM      = 0;
    localparam int unsigned FLAG_ALU_EN      = 1;
    localparam int unsigned FLAG_ALU_OP_LO   = 2;
    localparam int unsigned FLAG_ALU_OP_HI   = 4;
    localparam int unsigned FLAG_RF_EN       = 5;
    localparam int unsigned FLAG_RF_RW       = 6;
    localparam int unsigned FLAG_IS_BRANCH   = 7;

    localparam logic [CLASS_W-1:0] HALT_CLASS = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        StFetch    = 3'd0,
        StDecode   = 3'd1,
        StExecute1 = 3'd2,
        StExecute2 = 3'd3,
        StHalt     = 3'd4
    } cpu_state_e;

    function automatic logic [CLASS_W-1:0] ir_uop_class(input logic [IR_W-1:0] ir);
        return ir[UOP_CLASS_HI:UOP_CLASS_LO];
    endfunction

endpackage

// File: rtl/micro_sequencer_udecode_fields.sv
// Purely combinational field extraction from the instruction register.
module udecode_fields
    import micro_sequencer_pkg::*;
(
    input  logic [IR_W-1:0]     ir_i,
    output logic [CLASS_W-1:0]  uop_class_o,
    output logic                is_imm_active_md_o,
    output logic [REG_W-1:0]    reg_dst_md_o,
    output logic [REG_W-1:0]    reg_src_md_o,
    output logic [IMM_W-1:0]    imm_md_o,
    output logic [BT_W-1:0]     branch_target_md_o,
    output logic                alu_en_md_o,
    output logic [ALU_OP_W-1:0] alu_op_md_o,
    output logic                reg_file_en_md_o,
    output logic                reg_file_rw_md_o,
    output logic                is_branch_md_o
);

    // Reserved bits of the micro-instruction word carry no meaning.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir_i[40], ir_i[35], ir_i[9:8]};

    always_comb begin
        uop_class_o        = ir_uop_class(ir_i);
        reg_dst_md_o       = ir_i[REG_DST_HI:REG_DST_LO];
        reg_src_md_o       = ir_i[REG_SRC_HI:REG_SRC_LO];
        imm_md_o           = ir_i[IMM_HI:IMM_LO];
        branch_target_md_o = ir_i[BT_HI:BT_LO];
        is_imm_active_md_o = ir_i[FLAG_IS_IMM];
        alu_en_md_o        = ir_i[FLAG_ALU_EN];
        alu_op_md_o        = ir_i[FLAG_ALU_OP_HI:FLAG_ALU_OP_LO];
        reg_file_en_md_o   = ir_i[FLAG_RF_EN];
        reg_file_rw_md_o   = ir_i[FLAG_RF_RW];
        is_branch_md_o     = ir_i[FLAG_IS_BRANCH];
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer: fetches micro-instructions, walks them through
// DECODE/EXECUTE1/EXECUTE2 and advances or branches the micro-PC.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int unsigned          USTORE_AW = 10,
    parameter logic [USTORE_AW-1:0] RESET_UPC = '0
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset,
    output logic                 ustore_req,
    output logic [USTORE_AW-1:0] ustore_addr,
    input  logic                 ustore_valid,
    input  logic [IR_W-1:0]      ustore_data,
    input  logic                 branch_cond,
    output logic [STATE_W-1:0]   cpu_state,
    output logic [USTORE_AW-1:0] upc,
    output logic                 is_imm_active_md,
    output logic [REG_W-1:0]     reg_dst_md,
    output logic [REG_W-1:0]     reg_src_md,
    output logic [IMM_W-1:0]     imm_md,
    output logic [BT_W-1:0]      branch_target_md,
    output logic                 alu_en_md,
    output logic [ALU_OP_W-1:0]  alu_op_md,
    output logic                 reg_file_en_md,
    output logic                 reg_file_rw_md,
    output logic                 is_branch_md,
    output logic                 halted
);

    cpu_state_e             state_q, state_d;
    logic [USTORE_AW-1:0]   upc_q, upc_d;
    logic [IR_W-1:0]        ir_q, ir_d;
    logic                   req_q, req_d;
    logic                   halted_q, halted_d;
    logic [CLASS_W-1:0]     uop_class;

    udecode_fields u_udecode_fields (
        .ir_i               (ir_q),
        .uop_class_o        (uop_class),
        .is_imm_active_md_o (is_imm_active_md),
        .reg_dst_md_o       (reg_dst_md),
        .reg_src_md_o       (reg_src_md),
        .imm_md_o           (imm_md),
        .branch_target_md_o (branch_target_md),
        .alu_en_md_o        (alu_en_md),
        .alu_op_md_o        (alu_op_md),
        .reg_file_en_md_o   (reg_file_en_md),
        .reg_file_rw_md_o   (reg_file_rw_md),
        .is_branch_md_o     (is_branch_md)
    );

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        ir_d    = ir_q;
        case (state_q)
            StFetch: begin
                // Valid only counts once the request is actually on the bus.
                if (req_q && ustore_valid) begin
                    ir_d    = ustore_data;
                    state_d = StDecode;
                end
            end
            StDecode:   state_d = (uop_class == HALT_CLASS) ? StHalt : StExecute1;
            StExecute1: state_d = StExecute2;
            StExecute2: begin
                state_d = StFetch;
                if (is_branch_md && branch_cond) begin
                    upc_d = USTORE_AW'(branch_target_md);
                end else begin
                    upc_d = upc_q + 1'b1;
                end
            end
            StHalt:     state_d = StHalt;
            default:    state_d = StFetch;
        endcase
        req_d    = (state_d == StFetch);
        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q  <= StFetch;
            upc_q    <= RESET_UPC;
            ir_q     <= '0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            upc_q    <= upc_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            halted_q <= halted_d;
        end
    end

    assign ustore_req  = req_q;
    assign ustore_addr = upc_q;
    assign upc         = upc_q;
    assign cpu_state   = state_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus a
// randomized instruction stream checked against an instruction-level model.
module tb_micro_sequencer;
    import micro_sequencer_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        ustore_valid;
    logic [43:0] ustore_data;
    logic        branch_cond;

    logic        ustore_req, halted, is_imm_active_md, alu_en_md;
    logic        reg_file_en_md, reg_file_rw_md, is_branch_md;
    logic [9:0]  ustore_addr, upc, branch_target_md;
    logic [2:0]  cpu_state, alu_op_md;
    logic [3:0]  reg_dst_md, reg_src_md;
    logic [10:0] imm_md;

    logic        w_unused_req, w_unused_halted, w_unused_imm_act, w_unused_alu_en;
    logic        w_unused_rf_en, w_unused_rf_rw, w_unused_is_br;
    logic [9:0]  w_ustore_addr, w_upc, w_unused_bt;
    logic [2:0]  w_unused_state, w_unused_alu_op;
    logic [3:0]  w_unused_dst, w_unused_src;
    logic [10:0] w_unused_imm;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  m_upc;

    always #5 sys_clk = ~sys_clk;

    micro_sequencer dut (
        .sys_clk (sys_clk), .sys_reset (sys_reset),
        .ustore_req (ustore_req), .ustore_addr (ustore_addr),
        .ustore_valid (ustore_valid), .ustore_data (ustore_data),
        .branch_cond (branch_cond), .cpu_state (cpu_state), .upc (upc),
        .is_imm_active_md (is_imm_active_md), .reg_dst_md (reg_dst_md),
        .reg_src_md (reg_src_md), .imm_md (imm_md),
        .branch_target_md (branch_target_md), .alu_en_md (alu_en_md),
        .alu_op_md (alu_op_md), .reg_file_en_md (reg_file_en_md),
        .reg_file_rw_md (reg_file_rw_md), .is_branch_md (is_branch_md),
        .halted (halted)
    );

    micro_sequencer #(.USTORE_AW (10), .RESET_UPC (10'h3FF)) dut_wrap (
        .sys_clk (sys_clk), .sys_reset (sys_reset),
        .ustore_req (w_unused_req), .ustore_addr (w_ustore_addr),
        .ustore_valid (ustore_valid), .ustore_data (ustore_data),
        .branch_cond (branch_cond), .cpu_state (w_unused_state), .upc (w_upc),
        .is_imm_active_md (w_unused_imm_act), .reg_dst_md (w_unused_dst),
        .reg_src_md (w_unused_src), .imm_md (w_unused_imm),
        .branch_target_md (w_unused_bt), .alu_en_md (w_unused_alu_en),
        .alu_op_md (w_unused_alu_op), .reg_file_en_md (w_unused_rf_en),
        .reg_file_rw_md (w_unused_rf_rw), .is_branch_md (w_unused_is_br),
        .halted (w_unused_halted)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [43:0] mk(input logic [2:0] cls, input logic [3:0] dst,
                                       input logic [3:0] src, input logic [10:0] imm,
                                       input logic [9:0] bt, input logic [7:0] flags);
        return {cls, 1'b0, dst, 1'b0, src, imm, bt, 2'b00, flags};
    endfunction

    // Expected decode bundle, extracted from the word with plain arithmetic.
    function automatic logic [36:0] exp_dec(input logic [43:0] w);
        longint unsigned v;
        v = 64'(w);
        return {1'(v % 2), 4'((v >> 36) % 16), 4'((v >> 31) % 16), 11'((v >> 20) % 2048),
                10'((v >> 10) % 1024), 1'((v >> 1) % 2), 3'((v >> 2) % 8),
                1'((v >> 5) % 2), 1'((v >> 6) % 2), 1'((v >> 7) % 2)};
    endfunction

    function automatic logic [36:0] act_dec();
        return {is_imm_active_md, reg_dst_md, reg_src_md, imm_md, branch_target_md,
                alu_en_md, alu_op_md, reg_file_en_md, reg_file_rw_md, is_branch_md};
    endfunction

    function automatic logic [43:0] rnd_word();
        return 44'({$urandom, $urandom});
    endfunction

    // One full instruction starting in FETCH at m_upc; stops in DECODE for HALT class.
    task automatic run_instr(input logic [43:0] w, input int waits, input logic cond);
        logic [9:0] nxt;
        for (int i = 0; i < waits; i++) begin
            ustore_valid = 1'b0;
            ustore_data  = rnd_word();
            check("wait_req", ustore_req, 1);
            check("wait_addr", ustore_addr, m_upc);
            check("wait_state", cpu_state, StFetch);
            step();
        end
        ustore_valid = 1'b1;
        ustore_data  = w;
        check("fetch_req", ustore_req, 1);
        check("fetch_addr", ustore_addr, m_upc);
        step();
        ustore_valid = 1'($urandom_range(0, 1));
        ustore_data  = rnd_word();
        check("dec_state", cpu_state, StDecode);
        check("dec_fields", act_dec(), exp_dec(w));
        check("dec_req", ustore_req, 0);
        if ((w >> 41) == 44'd7) return;
        step();
        check("ex1_state", cpu_state, StExecute1);
        check("ex1_fields", act_dec(), exp_dec(w));
        branch_cond = cond;
        step();
        check("ex2_state", cpu_state, StExecute2);
        check("ex2_req", ustore_req, 0);
        if (((w >> 7) % 2) == 1 && cond) nxt = 10'((w >> 10) % 1024);
        else nxt = 10'((32'(m_upc) + 1) % 1024);
        step();
        m_upc = nxt;
        check("next_state", cpu_state, StFetch);
        check("next_upc", upc, m_upc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [43:0] w;
        logic [9:0]  held_upc;

        sys_reset    = 1'b1;
        ustore_valid = 1'b1;
        ustore_data  = rnd_word();
        branch_cond  = 1'b1;
        step();
        step();
        check("rst_state", cpu_state, StFetch);
        check("rst_upc", upc, 10'h000);
        check("rst_req", ustore_req, 0);
        check("rst_halted", halted, 0);
        check("rst_dec", act_dec(), 37'd0);
        check("rst_upc_wrapdut", w_upc, 10'h3FF);

        sys_reset    = 1'b0;
        ustore_valid = 1'b0;
        check("req_deassert_cycle", ustore_req, 0);
        step();
        check("req_after_rst", ustore_req, 1);
        check("addr_after_rst", ustore_addr, 10'h000);

        // Basic instruction: flags 0x23, imm 0x155, valid on first FETCH cycle.
        w = mk(3'b000, 4'h3, 4'h5, 11'h155, 10'h000, 8'h23);
        ustore_valid = 1'b1;
        ustore_data  = w;
        check("basic_fetch_state", cpu_state, StFetch);
        step();
        ustore_data = ~w;
        check("basic_dec_state", cpu_state, StDecode);
        check("basic_alu_en", alu_en_md, 1);
        check("basic_is_imm", is_imm_active_md, 1);
        check("basic_rf_en", reg_file_en_md, 1);
        check("basic_imm", imm_md, 11'h155);
        check("basic_is_branch", is_branch_md, 0);
        step();
        check("basic_ex1_state", cpu_state, StExecute1);
        check("basic_ex1_imm", imm_md, 11'h155);
        step();
        check("basic_ex2_state", cpu_state, StExecute2);
        ustore_valid = 1'b0;
        step();
        check("basic_next_state", cpu_state, StFetch);
        check("basic_next_addr", ustore_addr, 10'h001);
        check("wrap_next_addr", w_ustore_addr, 10'h000);
        m_upc = 10'h001;

        // Fetch wait, then taken and not-taken branch.
        w = mk(3'b010, 4'h1, 4'h2, 11'h7FF, 10'h2A0, 8'h80);
        run_instr(w, 3, 1'b1);
        check("branch_taken_addr", ustore_addr, 10'h2A0);
        run_instr(w, 0, 1'b0);
        check("branch_not_taken_addr", ustore_addr, 10'h2A1);

        // Reset during a FETCH wait.
        ustore_valid = 1'b0;
        step();
        sys_reset = 1'b1;
        step();
        check("rst_wait_state", cpu_state, StFetch);
        check("rst_wait_req", ustore_req, 0);
        check("rst_wait_ir", act_dec(), 37'd0);
        check("rst_wait_upc", upc, 10'h000);
        sys_reset = 1'b0;
        step();
        m_upc = 10'h000;

        // Reset during EXECUTE1.
        ustore_valid = 1'b1;
        ustore_data  = mk(3'b001, 4'hF, 4'hE, 11'h2AA, 10'h155, 8'hFF);
        step();
        ustore_valid = 1'b0;
        step();
        check("ex1_pre_rst_state", cpu_state, StExecute1);
        sys_reset = 1'b1;
        step();
        check("rst_ex1_state", cpu_state, StFetch);
        check("rst_ex1_req", ustore_req, 0);
        check("rst_ex1_ir", act_dec(), 37'd0);
        sys_reset = 1'b0;
        step();

        // HALT class: hold everything for 20 cycles, then recover via reset.
        w = rnd_word();
        w[43:41] = 3'b111;
        run_instr(w, 1, 1'b0);
        held_upc = m_upc;
        step();
        for (int i = 0; i < 20; i++) begin
            check("halt_state", cpu_state, StHalt);
            check("halt_flag", halted, 1);
            check("halt_req", ustore_req, 0);
            check("halt_upc", upc, held_upc);
            check("halt_ir", act_dec(), exp_dec(w));
            ustore_valid = 1'($urandom_range(0, 1));
            ustore_data  = rnd_word();
            branch_cond  = 1'($urandom_range(0, 1));
            step();
        end
        sys_reset = 1'b1;
        step();
        check("halt_rst_state", cpu_state, StFetch);
        check("halt_rst_flag", halted, 0);
        check("halt_rst_upc", upc, 10'h000);
        sys_reset    = 1'b0;
        ustore_valid = 1'b0;
        step();
        m_upc = 10'h000;

        // Randomized instruction stream, no HALT class.
        for (int n = 0; n < 300; n++) begin
            w = rnd_word();
            w[43:41] = 3'($urandom_range(0, 6));
            run_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
